// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_MEM,
    HZ_BR,
    HZ_LDUSE
  } hz_cause_e;

  localparam int unsigned MAX_WAIT_DEF = 16;
  localparam int unsigned WAIT_W       = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hold/flush sequencer for the 5-stage CPU: load-use, taken branch in MEM,
// and data-memory wait freeze with timeout, plus stall/flush counters.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned REG_W    = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             MemReadEX,
  input  logic [REG_W-1:0] writeregEX,
  input  logic [REG_W-1:0] rsID,
  input  logic [REG_W-1:0] rtID,
  input  logic             useRtID,
  input  logic             beqMEM,
  input  logic             bneMEM,
  input  logic             ALUzeroMEM,
  input  logic             MemReadMEM,
  input  logic             MemWriteMEM,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pcsrcMEM,
  output logic             stallIF,
  output logic             stallID,
  output logic             holdEX,
  output logic             holdMEM,
  output logic             flushID,
  output logic             flushEX,
  output logic             flushMEM,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              memop, taken, lduse;
  hz_cause_e         cause;

  // Hazard arbitration and next-state; controls are zero-latency.
  always_comb begin
    memop = MemReadMEM | MemWriteMEM;
    taken = (beqMEM & ALUzeroMEM) | (bneMEM & ~ALUzeroMEM);
    lduse = MemReadEX && (writeregEX != '0) &&
            ((writeregEX == rsID) || (useRtID && (writeregEX == rtID)));

    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    cause         = HZ_NONE;
    dmem_req      = 1'b0;

    if (state_q == MEM_WAIT) begin
      cause    = HZ_MEM;
      dmem_req = 1'b1;
      if (dmem_ready) begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
        // Abandon the access; the sticky flag records it.
        timeout_err_d = 1'b1;
        state_d       = RUN;
        wait_cnt_d    = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end else begin
      dmem_req = memop;
      if (memop && !dmem_ready) begin
        cause      = HZ_MEM;
        state_d    = MEM_WAIT;
        wait_cnt_d = WAIT_W'(1);
      end else if (taken) begin
        cause = HZ_BR;
      end else if (lduse) begin
        cause = HZ_LDUSE;
      end
    end

    stallIF  = (cause == HZ_MEM) || (cause == HZ_LDUSE);
    stallID  = (cause == HZ_MEM) || (cause == HZ_LDUSE);
    holdEX   = (cause == HZ_MEM);
    holdMEM  = (cause == HZ_MEM);
    pcsrcMEM = (cause == HZ_BR);
    flushID  = (cause == HZ_BR);
    flushEX  = (cause == HZ_BR) || (cause == HZ_LDUSE);
    flushMEM = (cause == HZ_BR);

    if (!reset_n) begin
      {dmem_req, pcsrcMEM, stallIF, stallID, holdEX, holdMEM,
       flushID, flushEX, flushMEM} = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stallIF),
    .count   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (pcsrcMEM),
    .count   (flush_cnt)
  );

endmodule
